// File: rtl/lemming_pkg.sv
// Shared definitions for the Lemmings walker and its 1-D terrain model.
// The walker's Moore outputs are one-hot over {walk_left, walk_right, aaah}.
package lemming_pkg;

  localparam logic [2:0] WALK_L = 3'b100;
  localparam logic [2:0] WALK_R = 3'b010;
  localparam logic [2:0] FALL   = 3'b001;

  typedef struct packed {
    logic bump_left;
    logic bump_right;
    logic ground;
    logic walk_left;
    logic walk_right;
    logic aaah;
  } lemming_io_t;

  function automatic logic is_onehot3(input logic [2:0] v);
    logic one_s;
    case (v)
      WALK_L, WALK_R, FALL: one_s = 1'b1;
      default:              one_s = 1'b0;
    endcase
    return one_s;
  endfunction

endpackage

// File: rtl/lemming_world_step_timer.sv
// Free-running divider that raises tick on the last cycle of every
// STEP_CYCLES-cycle period; tick is registered so it lines up with step_cnt.
module step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tick_q;

  // Next count with wrap at the last cycle of the period.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q == LAST) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter and the tick flag that mirrors cnt_q == LAST.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= {CW{1'b0}};
      tick_q <= (LAST == {CW{1'b0}});
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/lemming_world.sv
// 1-D terrain seen by the Lemmings walker: reports walls and floor, moves the
// lemming on step ticks, and fills a hole after the lemming falls through it.
module lemming_world
  import lemming_pkg::*;
#(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] HOLE_MAP   = {WIDTH{1'b0}},
  parameter int              START_POS   = 8,
  parameter int              STEP_CYCLES = 4,
  parameter int              FALL_DEPTH  = 3
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   walk_left,
  input  logic                                   walk_right,
  input  logic                                   aaah,
  output logic                                   bump_left,
  output logic                                   bump_right,
  output logic                                   ground,
  output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] pos,
  output logic                                   landed,
  output logic                                   error
);

  localparam int PW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = $clog2(FALL_DEPTH + 1);
  localparam logic [PW-1:0] POS_MAX   = PW'(WIDTH - 1);
  localparam logic [PW-1:0] POS_START = PW'(START_POS);
  localparam logic [FW-1:0] FALL_LAST = FW'(FALL_DEPTH - 1);

  if (START_POS >= WIDTH || START_POS < 0) begin : g_bad_start_pos
    $error("lemming_world: START_POS must lie inside 0..WIDTH-1");
  end

  logic [PW-1:0]    pos_q,      pos_d;
  logic [WIDTH-1:0] hole_q,     hole_d;
  logic [FW-1:0]    fall_cnt_q, fall_cnt_d;
  logic             landed_q,   landed_d;
  logic             error_q,    error_d;
  logic             tick_s;
  logic [2:0]       walk_bits_s;
  logic             legal_s;
  lemming_io_t      io_s;

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk_i  (clk),
    .reset_i(reset),
    .tick_o (tick_s)
  );

  // Everything below depends only on registers and the walker's Moore outputs.
  assign io_s.walk_left  = walk_left;
  assign io_s.walk_right = walk_right;
  assign io_s.aaah       = aaah;
  assign io_s.ground     = ~hole_q[pos_q];
  assign io_s.bump_left  = walk_left  & io_s.ground & (pos_q == {PW{1'b0}});
  assign io_s.bump_right = walk_right & io_s.ground & (pos_q == POS_MAX);

  assign walk_bits_s = {io_s.walk_left, io_s.walk_right, io_s.aaah};
  assign legal_s     = is_onehot3(walk_bits_s);

  // Next-state: falling/filling while airborne, stepping while on the floor.
  always_comb begin
    pos_d      = pos_q;
    hole_d     = hole_q;
    fall_cnt_d = fall_cnt_q;
    landed_d   = 1'b0;
    error_d    = error_q | ~legal_s;
    if (!io_s.ground) begin
      if (io_s.aaah) begin
        if (fall_cnt_q == FALL_LAST) begin
          hole_d[pos_q] = 1'b0;
          fall_cnt_d    = {FW{1'b0}};
          landed_d      = 1'b1;
        end else begin
          fall_cnt_d = fall_cnt_q + FW'(1);
        end
      end else begin
        // Walker still lags by one cycle after the floor vanished.
        fall_cnt_d = fall_cnt_q;
      end
    end else begin
      fall_cnt_d = {FW{1'b0}};
      if (tick_s && legal_s) begin
        case (walk_bits_s)
          WALK_L: begin
            if (pos_q != {PW{1'b0}}) begin
              pos_d = pos_q - PW'(1);
            end else begin
              pos_d = pos_q;
            end
          end
          WALK_R: begin
            if (pos_q != POS_MAX) begin
              pos_d = pos_q + PW'(1);
            end else begin
              pos_d = pos_q;
            end
          end
          default: pos_d = pos_q;
        endcase
      end else begin
        pos_d = pos_q;
      end
    end
  end

  // State registers; reset wins over any fall or step in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q      <= POS_START;
      hole_q     <= HOLE_MAP;
      fall_cnt_q <= {FW{1'b0}};
      landed_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      pos_q      <= pos_d;
      hole_q     <= hole_d;
      fall_cnt_q <= fall_cnt_d;
      landed_q   <= landed_d;
      error_q    <= error_d;
    end
  end

  assign bump_left  = io_s.bump_left;
  assign bump_right = io_s.bump_right;
  assign ground     = io_s.ground;
  assign pos        = pos_q;
  assign landed     = landed_q;
  assign error      = error_q;

endmodule

// File: tb/tb_lemming_world.sv
// Closed-loop check of lemming_world against a cell-array reference model,
// using directed scenarios followed by randomized walker traffic.
module tb_lemming_world;

  localparam int W  = 8;
  localparam int SP = 3;
  localparam int SC = 2;
  localparam int FD = 3;
  localparam logic [7:0] HMAP = 8'b0010_0000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       walk_left = 1'b0, walk_right = 1'b0, aaah = 1'b0;
  logic       bump_left, bump_right, ground, landed, error;
  logic [2:0] pos;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: plain integers and a per-cell floor array.
  int m_pos, m_fall, m_phase, m_landed, m_err;
  int m_hole [W];

  always #5 clk = ~clk;

  lemming_world #(
    .WIDTH(W), .HOLE_MAP(HMAP), .START_POS(SP), .STEP_CYCLES(SC), .FALL_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .walk_left(walk_left), .walk_right(walk_right),
    .aaah(aaah), .bump_left(bump_left), .bump_right(bump_right), .ground(ground),
    .pos(pos), .landed(landed), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int m_ground();
    return (m_hole[m_pos] == 0) ? 1 : 0;
  endfunction

  task automatic model_edge(input bit r, input bit wl, input bit wr, input bit ah);
    int g, legal;
    if (r) begin
      m_pos = SP; m_fall = 0; m_phase = 0; m_landed = 0; m_err = 0;
      for (int i = 0; i < W; i++) m_hole[i] = HMAP[i];
      return;
    end
    g      = m_ground();
    legal  = (int'(wl) + int'(wr) + int'(ah) == 1);
    m_landed = 0;
    if (!legal) m_err = 1;
    if (g == 0 && ah) begin
      if (m_fall == FD - 1) begin
        m_hole[m_pos] = 0; m_fall = 0; m_landed = 1;
      end else m_fall++;
    end else if (g == 1) begin
      m_fall = 0;
      if (m_phase == SC - 1 && legal) begin
        if (wl && m_pos > 0) m_pos--;
        else if (wr && m_pos < W - 1) m_pos++;
      end
    end
    m_phase = (m_phase + 1) % SC;
  endtask

  // One clock: drive inputs, check combinational outputs, clock, check state.
  task automatic step(input bit r, input bit wl, input bit wr, input bit ah);
    int g;
    reset = r; walk_left = wl; walk_right = wr; aaah = ah;
    #1;
    g = m_ground();
    chk("ground_pre", ground, g);
    chk("bump_left", bump_left, (wl && g == 1 && m_pos == 0) ? 1 : 0);
    chk("bump_right", bump_right, (wr && g == 1 && m_pos == W - 1) ? 1 : 0);
    @(posedge clk);
    model_edge(r, wl, wr, ah);
    #1;
    chk("pos", pos, m_pos);
    chk("ground", ground, m_ground());
    chk("landed", landed, m_landed);
    chk("error", error, m_err);
  endtask

  initial begin
    int land_cnt, guard;
    bit wl, wr, ah;
    int sel;

    // Scenario 1: reset then walk left into the wall.
    step(1, 0, 0, 0);
    chk("reset_pos", pos, 3);
    chk("reset_ground", ground, 1);
    chk("reset_error", error, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    chk("s1_wall_pos", pos, 0);
    chk("s1_bump_left", bump_left, 1);
    chk("s1_bump_right", bump_right, 0);

    // Scenarios 2-3: walk into the hole, fall, fill, continue to right wall.
    step(1, 0, 0, 0);
    guard = 0;
    while (ground && guard < 20) begin step(0, 0, 1, 0); guard++; end
    chk("s2_reached_hole", guard < 20, 1);
    chk("s2_hole_pos", pos, 5);
    step(0, 0, 1, 0);
    land_cnt = 0;
    for (int i = 0; i < 3; i++) begin step(0, 0, 0, 1); land_cnt += landed; end
    chk("s2_landed_after_3", landed, 1);
    step(0, 0, 0, 1);
    land_cnt += landed;
    chk("s2_landed_once", land_cnt, 1);
    chk("s2_ground_after", ground, 1);
    chk("s2_pos_after", pos, 5);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
    chk("s3_pos7", pos, 7);
    chk("s3_bump_right", bump_right, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    chk("s3_revisit_pos", pos, 5);
    chk("s3_revisit_ground", ground, 1);

    // Scenario 4: illegal pattern sets a sticky error.
    step(0, 1, 1, 0);
    chk("s4_error_set", error, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    chk("s4_error_sticky", error, 1);
    step(1, 0, 0, 0);
    chk("s4_error_clear", error, 0);

    // Scenario 5: reset mid-fall restores the original terrain.
    guard = 0;
    while (ground && guard < 20) begin step(0, 0, 1, 0); guard++; end
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    chk("s5_still_falling", ground, 0);
    step(1, 0, 0, 1);
    chk("s5_pos", pos, 3);
    chk("s5_ground", ground, 1);
    chk("s5_error", error, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("s5_hole_back", ground, 0);

    // Scenario 6: all-zero inputs flag an error and never move the lemming.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("s6_error", error, 1);
    chk("s6_pos", pos, 3);

    // Randomized walker-like traffic with occasional resets and violations.
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 99));
      wl = 0; wr = 0; ah = 0;
      if (sel < 3) step(1, 0, 0, 0);
      else begin
        if (sel < 6) begin
          wl = 1'($urandom); wr = 1'($urandom); ah = 1'($urandom);
        end else if (!ground && sel < 90) ah = 1;
        else if (sel < 50) wl = 1;
        else wr = 1;
        step(0, wl, wr, ah);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
